fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the fetch stage when instruction memory has a request/response interface with variable latency.
- Issues one fetch per instruction and drives the PC write enable. Drives the IF/ID write-enable and flush.
- Handles decode stalls and branch redirects that arrive while a fetch is in flight, and counts front-end stall cycles.
- Sits between the PC register, the PC-select mux, instruction memory and the IF/ID register.

Parameters:
- ADDR_W, 32: PC / memory address width.
- DATA_W, 32: instruction width.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_f  input  ADDR_W  current PC from the PC register.
- pcsrc_e  input  1  redirect from EX. The PC mux selects the target while this is high.
- stall_d  input  1  decode stall from the hazard unit.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  ADDR_W  fetch address.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response valid, one per accepted request.
- imem_rsp_data  input  DATA_W  fetched instruction.
- pc_write  output  1  PC register load enable.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID clear to NOP.
- instr_f  output  DATA_W  instruction to IF/ID.
- stall_cnt  output  CNT_W  saturating count of cycles with no IF/ID load and no flush.

Behaviour:
- One clock domain. Synchronous active-high reset. At most one request outstanding.
- State register: IDLE, REQ, WAIT, HOLD, DRAIN. Reset state is IDLE.
- Reset values: state IDLE, hold register 0, stall_cnt 0. All control outputs are 0 while reset is high.
- Control outputs are combinational from state and inputs (Mealy). They take effect at the next clock edge.
- pcsrc_e has priority over stall_d and over the response in every state.
- ifid_flush=1 and pc_write=1 in any cycle where pcsrc_e=1 and state is not IDLE.
- IDLE: all outputs 0. Go to REQ the next cycle.
- REQ:
  - Drive imem_req_valid=1 and imem_req_addr=pc_f.
  - Ready and no redirect: go to WAIT.
  - Redirect with ready=0: the request is withdrawn (the memory tolerates this); stay in REQ, which presents the new pc_f next cycle.
  - Redirect with ready=1: the accepted request is stale; go to DRAIN.
- WAIT:
  - imem_req_valid=0.
  - Response, no redirect, stall_d=0: instr_f=imem_rsp_data, ifid_write=1, pc_write=1 (PC+4 path); go to REQ.
  - Response, no redirect, stall_d=1: capture the data into the hold register; go to HOLD.
  - Response with redirect: discard the data; go to REQ.
  - Redirect without a response: go to DRAIN.
- HOLD:
  - instr_f=hold register.
  - stall_d=0: ifid_write=1, pc_write=1; go to REQ.
  - Redirect: discard; go to REQ.
- DRAIN:
  - Wait for imem_rsp_valid and discard the data; go to REQ.
  - A further redirect in DRAIN keeps state DRAIN with pc_write=1.
  - A response and a redirect in the same cycle go to REQ.
- Response timing: imem_rsp_valid may arrive one cycle after acceptance at the earliest. It is never in the same cycle as acceptance.
- Responses outside WAIT/DRAIN are ignored. They are an assertion error in simulation.
- stall_cnt increments every non-IDLE cycle with ifid_write=0 and ifid_flush=0. It saturates at all-ones and never wraps. It is cleared only by reset.
- instr_f is 0 whenever ifid_write=0.
- Reset mid-fetch: return to IDLE. Any response arriving after reset is ignored because the state is IDLE.

Decomposition:
- Shared package holds the state enum (IDLE, REQ, WAIT, HOLD, DRAIN) and the NOP encoding 32'h00000013 used by IF/ID on flush.
- One natural sub-module, sat_counter (CNT_W, increment, saturate), for stall_cnt.
- Everything else is a single FSM with a DATA_W hold register.

Test Plan:
- Zero-wait fetch:
  - Stimulus: ready=1 always, response one cycle after acceptance, pc_f 0x0,0x4,0x8.
  - Required: ifid_write every 2nd cycle; instr_f matches 0x00500093 etc.; stall_cnt increments once per fetch.
- Decode stall:
  - Stimulus: response 0xDEADBEEF arrives with stall_d=1 for 3 cycles.
  - Required: state HOLD; pc_write=0 and ifid_write=0 for 3 cycles; then ifid_write=1 with instr_f=0xDEADBEEF.
- Redirect in WAIT:
  - Stimulus: pcsrc_e=1 two cycles before a response.
  - Required: ifid_flush=1 and pc_write=1 that cycle; next response discarded (no ifid_write); the next request address equals the target, e.g. 0x100.
- Redirect coinciding with response:
  - Stimulus: pcsrc_e=1 and rsp_valid=1 in the same cycle.
  - Required: data discarded, ifid_flush=1; next cycle REQ with the target address.
- Redirect in REQ with ready=0:
  - Stimulus: pcsrc_e=1 while the request is not accepted.
  - Required: no DRAIN; the next cycle's request carries the new pc_f.
- Reset mid-fetch and saturation:
  - Stimulus: assert reset in WAIT; separately, a CNT_W=4 build held in WAIT for 20 cycles.
  - Required: reset gives IDLE with all outputs 0 and any late response ignored; stall_cnt saturates at 15.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer.
// Imported by the sequencer RTL.
package fetch_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t REQ   = 3'd1;
  localparam state_t WAIT  = 3'd2;
  localparam state_t HOLD  = 3'd3;
  localparam state_t DRAIN = 3'd4;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus.
// master = fetch sequencer, slave = memory.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter, cleared only by reset.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for a variable-latency instruction memory.
// One request in flight; redirects override stalls and responses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_f,
  input  logic              pcsrc_e,
  input  logic              stall_d,
  fetch_ctrl_if.master      imem,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [DATA_W-1:0] instr_f,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state;
  state_t            nxt;
  logic [DATA_W-1:0] hold;
  logic              hold_en;
  logic              req_valid;
  logic              cnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= nxt;
      if (hold_en) hold <= imem.rsp_data;
    end
  end

  always_comb begin
    nxt        = state;
    req_valid  = 1'b0;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    instr_f    = '0;
    hold_en    = 1'b0;
    if (!reset) begin
      if (pcsrc_e && (state != IDLE)) begin
        ifid_flush = 1'b1;
        pc_write   = 1'b1;
      end
      unique case (state)
        IDLE: nxt = REQ;
        REQ: begin
          req_valid = 1'b1;
          // an accepted request under redirect is stale
          if (imem.req_ready) nxt = pcsrc_e ? DRAIN : WAIT;
        end
        WAIT: begin
          if (pcsrc_e) begin
            nxt = imem.rsp_valid ? REQ : DRAIN;
          end else if (imem.rsp_valid) begin
            if (stall_d) begin
              hold_en = 1'b1;
              nxt     = HOLD;
            end else begin
              ifid_write = 1'b1;
              pc_write   = 1'b1;
              instr_f    = imem.rsp_data;
              nxt        = REQ;
            end
          end
        end
        HOLD: begin
          if (pcsrc_e) begin
            nxt = REQ;
          end else if (!stall_d) begin
            ifid_write = 1'b1;
            pc_write   = 1'b1;
            instr_f    = hold;
            nxt        = REQ;
          end
        end
        DRAIN: begin
          if (imem.rsp_valid) nxt = REQ;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = req_valid ? pc_f : '0;

  assign cnt_inc = (state != IDLE) && !ifid_write && !ifid_flush;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .count (stall_cnt)
  );

  rsp_only_in_flight: assert property (
    @(posedge clk) disable iff (reset)
    imem.rsp_valid |-> (state == WAIT || state == DRAIN)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, corner sequences,
// then random traffic against a transaction-level model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        pcsrc_e;
  logic        stall_d;
  logic        pc_write, ifid_write, ifid_flush;
  logic [31:0] instr_f;
  logic [15:0] stall_cnt;
  logic        pc_write2, ifid_write2, ifid_flush2;
  logic [31:0] instr_f2;
  logic [3:0]  stall_cnt2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_f       (pc_f),
    .pcsrc_e    (pcsrc_e),
    .stall_d    (stall_d),
    .imem       (bus.master),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .ifid_flush (ifid_flush),
    .instr_f    (instr_f),
    .stall_cnt  (stall_cnt)
  );

  fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .pc_f       (pc_f),
    .pcsrc_e    (pcsrc_e),
    .stall_d    (stall_d),
    .imem       (bus2.master),
    .pc_write   (pc_write2),
    .ifid_write (ifid_write2),
    .ifid_flush (ifid_flush2),
    .instr_f    (instr_f2),
    .stall_cnt  (stall_cnt2)
  );

  typedef struct {
    logic        rst, pcsrc, stall, rdy, rv;
    logic [31:0] data, pc;
    logic        v;
    logic [31:0] addr;
    logic        pw, iw, fl;
    logic [31:0] ins;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, pcsrc, stall, rdy, rv,
                     input logic [31:0] data, pc,
                     input logic v, input logic [31:0] addr,
                     input logic pw, iw, fl,
                     input logic [31:0] ins, input logic [15:0] cnt);
    vec_t r;
    r = '{rst, pcsrc, stall, rdy, rv, data, pc, v, addr, pw, iw, fl, ins, cnt};
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, pcsrc, stall, rdy, rv,
                       input logic [31:0] data, pc);
    reset         = rst;
    pcsrc_e       = pcsrc;
    stall_d       = stall;
    bus.req_ready = rdy;
    bus.rsp_valid = rv;
    bus.rsp_data  = data;
    pc_f          = pc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".v"},  {31'b0, bus.req_valid}, 32'd0);
    chk({tag, ".pw"}, {31'b0, pc_write}, 32'd0);
    chk({tag, ".iw"}, {31'b0, ifid_write}, 32'd0);
    chk({tag, ".fl"}, {31'b0, ifid_flush}, 32'd0);
    chk({tag, ".ins"}, instr_f, 32'd0);
  endtask

  // reference model state (transaction view)
  logic        m_start, m_busy, m_stale;
  logic [31:0] m_held[$];
  logic [15:0] m_cnt;
  logic        mem_out;
  int          mem_lat;

  initial begin
    bus2.req_ready = 1'b1;
    bus2.rsp_valid = 1'b0;
    bus2.rsp_data  = '0;
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc();

    add(1,0,0,0,0,32'h0,32'h0,       0,32'h0,  0,0,0,32'h0,0);
    add(0,0,0,0,0,32'h0,32'h0,       0,32'h0,  0,0,0,32'h0,0);
    add(0,0,0,1,0,32'h0,32'h0,       1,32'h0,  0,0,0,32'h0,0);
    add(0,0,0,0,1,32'h00500093,32'h0,0,32'h0,  1,1,0,32'h00500093,1);
    add(0,0,0,1,0,32'h0,32'h4,       1,32'h4,  0,0,0,32'h0,1);
    add(0,0,0,0,1,32'h00100113,32'h4,0,32'h0,  1,1,0,32'h00100113,2);
    add(0,0,0,1,0,32'h0,32'h8,       1,32'h8,  0,0,0,32'h0,2);
    add(0,0,1,0,1,32'hDEADBEEF,32'h8,0,32'h0,  0,0,0,32'h0,3);
    add(0,0,1,0,0,32'h0,32'h8,       0,32'h0,  0,0,0,32'h0,4);
    add(0,0,1,0,0,32'h0,32'h8,       0,32'h0,  0,0,0,32'h0,5);
    add(0,0,0,0,0,32'h0,32'h8,       0,32'h0,  1,1,0,32'hDEADBEEF,6);
    add(0,0,0,0,0,32'h0,32'hC,       1,32'hC,  0,0,0,32'h0,6);
    add(0,0,0,1,0,32'h0,32'hC,       1,32'hC,  0,0,0,32'h0,7);
    add(0,1,0,0,0,32'h0,32'hC,       0,32'h0,  1,0,1,32'h0,8);
    add(0,0,0,0,0,32'h0,32'h100,     0,32'h0,  0,0,0,32'h0,8);
    add(0,0,0,0,1,32'h11111111,32'h100,0,32'h0,0,0,0,32'h0,9);
    add(0,0,0,1,0,32'h0,32'h100,     1,32'h100,0,0,0,32'h0,10);
    add(0,1,0,0,1,32'h22222222,32'h100,0,32'h0,1,0,1,32'h0,11);
    add(0,0,0,0,0,32'h0,32'h200,     1,32'h200,0,0,0,32'h0,11);
    add(0,1,0,0,0,32'h0,32'h200,     1,32'h200,1,0,1,32'h0,12);
    add(0,1,0,1,0,32'h0,32'h300,     1,32'h300,1,0,1,32'h0,12);
    add(0,1,0,0,0,32'h0,32'h300,     0,32'h0,  1,0,1,32'h0,12);
    add(0,1,0,0,1,32'h33333333,32'h300,0,32'h0,1,0,1,32'h0,12);
    add(0,0,0,1,0,32'h0,32'h400,     1,32'h400,0,0,0,32'h0,12);
    add(0,0,0,0,1,32'h00A00513,32'h400,0,32'h0,1,1,0,32'h00A00513,13);
    add(0,0,0,1,0,32'h0,32'h404,     1,32'h404,0,0,0,32'h0,13);
    add(0,0,1,0,1,32'h44444444,32'h404,0,32'h0,0,0,0,32'h0,14);
    add(0,1,1,0,0,32'h0,32'h404,     0,32'h0,  1,0,1,32'h0,15);
    add(0,0,0,0,0,32'h0,32'h500,     1,32'h500,0,0,0,32'h0,15);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].pcsrc, tbl[i].stall, tbl[i].rdy,
            tbl[i].rv, tbl[i].data, tbl[i].pc);
      #2;
      chk($sformatf("r%0d.v", i), {31'b0, bus.req_valid}, {31'b0, tbl[i].v});
      if (tbl[i].v)
        chk($sformatf("r%0d.addr", i), bus.req_addr, tbl[i].addr);
      chk($sformatf("r%0d.pw", i), {31'b0, pc_write}, {31'b0, tbl[i].pw});
      chk($sformatf("r%0d.iw", i), {31'b0, ifid_write}, {31'b0, tbl[i].iw});
      chk($sformatf("r%0d.fl", i), {31'b0, ifid_flush}, {31'b0, tbl[i].fl});
      chk($sformatf("r%0d.ins", i), instr_f, tbl[i].ins);
      chk($sformatf("r%0d.cnt", i), {16'b0, stall_cnt}, {16'b0, tbl[i].cnt});
      cyc();
    end

    // reset while a fetch is outstanding; late response during reset
    drive(0, 0, 0, 1, 0, 0, 32'h600);
    #2;
    chk("mid.v", {31'b0, bus.req_valid}, 32'd1);
    chk("mid.addr", bus.req_addr, 32'h600);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 32'h600);
    #2;
    chk_zero("rst0");
    cyc();
    drive(1, 0, 0, 0, 1, 32'h55555555, 32'h600);
    #2;
    chk_zero("rst1");
    chk("rst1.cnt", {16'b0, stall_cnt}, 32'd0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 32'h700);
    #2;
    chk_zero("post");
    chk("post.cnt", {16'b0, stall_cnt}, 32'd0);
    chk("post.cnt4", {28'b0, stall_cnt2}, 32'd0);
    cyc();

    // narrow counter: dut4 sits in WAIT and must stop at 15
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0, 0, 32'h700);
      #2;
      if (k == 0) chk("post.req", {31'b0, bus.req_valid}, 32'd1);
      if (k == 9) chk("sat.mid", {28'b0, stall_cnt2}, 32'd9);
      cyc();
    end
    #2;
    chk("sat.cnt4", {28'b0, stall_cnt2}, 32'd15);
    chk("sat.cnt16", {16'b0, stall_cnt}, 32'd20);

    drive(1, 0, 0, 0, 0, 0, 0);
    cyc();
    m_start = 1'b1;
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_held.delete();
    m_cnt   = '0;
    mem_out = 1'b0;
    mem_lat = 0;

    for (int n = 0; n < 3000; n++) begin
      logic        pcs, stl, rdy, rv, issuing, flush, deliv, from_held;
      logic [31:0] data, pc, dd;
      pc   = $urandom & 32'hFFFF_FFFC;
      pcs  = ($urandom_range(0, 7) == 0);
      stl  = ($urandom_range(0, 2) == 0);
      rdy  = $urandom_range(0, 1) == 1;
      rv   = mem_out && (mem_lat == 0);
      data = $urandom;
      drive(0, pcs, stl, rdy, rv, data, pc);
      #2;

      issuing   = !m_start && !m_busy && (m_held.size() == 0);
      flush     = pcs && !m_start;
      deliv     = 1'b0;
      from_held = 1'b0;
      dd        = '0;
      if (!m_start && !pcs && !stl) begin
        if (m_held.size() > 0) begin
          deliv     = 1'b1;
          from_held = 1'b1;
          dd        = m_held[0];
        end else if (m_busy && rv && !m_stale) begin
          deliv = 1'b1;
          dd    = data;
        end
      end

      chk("rnd.v", {31'b0, bus.req_valid}, {31'b0, issuing});
      if (issuing) chk("rnd.addr", bus.req_addr, pc);
      chk("rnd.pw", {31'b0, pc_write}, {31'b0, flush || deliv});
      chk("rnd.iw", {31'b0, ifid_write}, {31'b0, deliv});
      chk("rnd.fl", {31'b0, ifid_flush}, {31'b0, flush});
      chk("rnd.ins", instr_f, dd);
      chk("rnd.cnt", {16'b0, stall_cnt}, {16'b0, m_cnt});

      if (!m_start && !deliv && !flush && (m_cnt != 16'hFFFF))
        m_cnt = m_cnt + 16'd1;
      if (m_start) begin
        m_start = 1'b0;
      end else begin
        if (m_busy && rv) begin
          m_busy = 1'b0;
          if (!pcs && !m_stale && stl) m_held.push_back(data);
          m_stale = 1'b0;
        end else if (m_busy && pcs) begin
          m_stale = 1'b1;
        end else if (issuing && rdy) begin
          m_busy  = 1'b1;
          m_stale = pcs;
        end
        if (pcs) m_held.delete();
        else if (from_held) void'(m_held.pop_front());
      end

      if (mem_out) begin
        if (mem_lat == 0) mem_out = 1'b0;
        else mem_lat--;
      end else if (bus.req_valid && rdy) begin
        mem_out = 1'b1;
        mem_lat = $urandom_range(0, 2);
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
